fetch_unit: RTL and testbench

Instruction fetch stage sitting directly downstream of `mainMem`. It issues 4-word burst reads starting at the current fetch PC, captures the returned words into an 8-entry prefetch FIFO, and presents instructions with their PCs to decode over a valid/ready handshake. A branch redirect flushes the FIFO, discards any beats still in flight, and restarts fetch at the new PC.

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: issues 4-word burst reads at the fetch PC, buffers beats in a prefetch FIFO
// and hands {insn, pc} to decode; FETCH_STATS_EN adds saturating fetched/stall/flush counters.
module fetch_unit #(
  parameter logic [31:0] START_ADDRESS = 32'h80020000,
  parameter int          MEM_LAT       = 2,
  parameter int          FIFO_DEPTH    = 8
) (
  input  logic        clock,
  input  logic        reset,
  output logic [0:31] mem_addr,
  output logic [0:1]  mem_acc_size,
  output logic        mem_wren,
  output logic        mem_enable,
  input  logic [0:31] mem_data_out,
  input  logic        mem_busy,
  output logic [0:31] insn,
  output logic [0:31] insn_pc,
  output logic        insn_valid,
  input  logic        insn_ready,
  input  logic        redirect,
  input  logic [0:31] redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [0:31] stat_fetched,
  output logic [0:31] stat_stall,
  output logic [0:31] stat_flush
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_BURST   = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PW + 1;
  localparam int CW    = $clog2(MEM_LAT + 4);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [1:0]       beat;
  logic [31:0]      fetch_pc;
  logic [31:0]      burst_addr;
  logic [31:0]      redirect_target;
  logic [31:0]      push_pc;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      fifo_insn [FIFO_DEPTH];
  logic [31:0]      fifo_pc   [FIFO_DEPTH];
  logic             issue;
  logic             push_en;
  logic             pop_en;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  // Only one burst is ever outstanding, so in IDLE the free-slot check is just the fill level.
  assign issue   = (state == S_IDLE) && (count <= CNT_W'(FIFO_DEPTH - 4)) && !mem_busy && !redirect;
  assign push_en = (state == S_BURST) && !redirect;
  assign pop_en  = insn_valid && insn_ready && !redirect;
  assign push_pc = fetch_pc + {28'd0, beat, 2'b00};

  assign mem_addr     = (state == S_IDLE) ? fetch_pc : burst_addr;
  assign mem_acc_size = 2'b01;
  assign mem_wren     = 1'b0;
  assign mem_enable   = !reset;

  assign insn_valid = (count != '0);
  assign insn       = insn_valid ? fifo_insn[rd_ptr] : '0;
  assign insn_pc    = insn_valid ? fifo_pc[rd_ptr]   : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      beat       <= '0;
      fetch_pc   <= START_ADDRESS;
      burst_addr <= START_ADDRESS;
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_target;
          end else if (issue) begin
            burst_addr <= fetch_pc;
            state      <= (MEM_LAT == 1) ? S_BURST : S_WAIT;
            cnt        <= CW'(MEM_LAT - 1);
            beat       <= '0;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            // Owed beats: the wait cycles after this one plus all four data beats.
            fetch_pc <= redirect_target;
            state    <= S_DISCARD;
            cnt      <= cnt + CW'(3);
          end else if (cnt == CW'(1)) begin
            state <= S_BURST;
            beat  <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_BURST: begin
          if (redirect) begin
            fetch_pc <= redirect_target;
            if (beat == 2'd3) begin
              state <= S_IDLE;
            end else begin
              state <= S_DISCARD;
              cnt   <= CW'(3) - CW'(beat);
            end
          end else if (beat == 2'd3) begin
            fetch_pc <= fetch_pc + 32'd16;
            state    <= S_IDLE;
          end else begin
            beat <= beat + 2'd1;
          end
        end
        default: begin
          if (redirect) fetch_pc <= redirect_target;
          if (cnt == CW'(1)) state <= S_IDLE;
          else               cnt   <= cnt - CW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  // NOTE: FIFO storage is not reset; count gates every read, so stale contents are never seen.
  always_ff @(posedge clock) begin
    if (push_en) begin
      fifo_insn[wr_ptr] <= mem_data_out;
      fifo_pc[wr_ptr]   <= push_pc;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
      stat_flush   <= '0;
    end else begin
      if (push_en && (stat_fetched != '1))   stat_fetched <= stat_fetched + 32'd1;
      if (!insn_valid && (stat_stall != '1)) stat_stall   <= stat_stall + 32'd1;
      if (redirect && (stat_flush != '1))    stat_flush   <= stat_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cold-start vector table, directed corner sequences and
// randomized traffic compared against a queue-based model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] START      = 32'h80020000;
  localparam int          MEM_LAT    = 2;
  localparam int          FIFO_DEPTH = 8;

  logic        clock;
  logic        reset;
  logic [0:31] mem_addr;
  logic [0:1]  mem_acc_size;
  logic        mem_wren;
  logic        mem_enable;
  logic [0:31] mem_data_out;
  logic        mem_busy;
  logic [0:31] insn;
  logic [0:31] insn_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic        redirect;
  logic [0:31] redirect_pc;
`ifdef FETCH_STATS_EN
  logic [0:31] stat_fetched;
  logic [0:31] stat_stall;
  logic [0:31] stat_flush;
`endif

  fetch_unit #(
    .START_ADDRESS(START),
    .MEM_LAT      (MEM_LAT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_acc_size(mem_acc_size),
    .mem_wren    (mem_wren),
    .mem_enable  (mem_enable),
    .mem_data_out(mem_data_out),
    .mem_busy    (mem_busy),
    .insn        (insn),
    .insn_pc     (insn_pc),
    .insn_valid  (insn_valid),
    .insn_ready  (insn_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_stall  (stat_stall),
    .stat_flush  (stat_flush)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_insn;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: a queue for the FIFO, absolute cycle numbers for the burst window.
  ent_t        m_fifo[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_burst_pc;
  int          m_burst_start;
  int          m_last_beat;
  bit          m_live;
  int          m_fetched;
  int          m_stall;
  int          m_flush;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a >= START && a < START + 32'd16) return 32'h11111111 * ((a - START) / 32'd4 + 32'd1);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_fetch_pc  = START;
    m_burst_pc  = START;
    m_last_beat = -1;
    m_live      = 0;
    m_fetched   = 0;
    m_stall     = 0;
    m_flush     = 0;
  endtask

  function automatic bit model_idle();
    return cyc > m_last_beat;
  endfunction

  task automatic model_step();
    bit do_issue;
    int k;
    if (reset) begin
      model_reset();
    end else begin
      if (m_fifo.size() == 0) m_stall++;
      if (redirect) begin
        m_fifo.delete();
        m_fetch_pc = 32'(redirect_pc) & 32'hFFFF_FFFC;
        m_live     = 0;
        m_flush++;
      end else begin
        do_issue = model_idle() && (FIFO_DEPTH - m_fifo.size() >= 4) && !mem_busy;
        if (m_fifo.size() != 0 && insn_ready) void'(m_fifo.pop_front());
        if (m_live && cyc >= m_burst_start && cyc <= m_last_beat) begin
          k = cyc - m_burst_start;
          m_fifo.push_back('{insn: mem_data_out, pc: m_burst_pc + 32'(4 * k)});
          m_fetched++;
          if (k == 3) begin
            m_fetch_pc = m_burst_pc + 32'd16;
            m_live     = 0;
          end
        end
        if (do_issue) begin
          m_burst_pc    = m_fetch_pc;
          m_burst_start = cyc + MEM_LAT;
          m_last_beat   = cyc + MEM_LAT + 3;
          m_live        = 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic compare_model();
    check("valid", 32'(insn_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) begin
      check("insn", insn, m_fifo[0].insn);
      check("insn_pc", insn_pc, m_fifo[0].pc);
    end
    check("mem_addr", mem_addr, model_idle() ? m_fetch_pc : m_burst_pc);
    check("mem_enable", 32'(mem_enable), 32'(!reset));
    check("mem_ctl", 32'({mem_acc_size, mem_wren}), 32'h2);
`ifdef FETCH_STATS_EN
    check("stat_fetched", stat_fetched, m_fetched);
    check("stat_stall", stat_stall, m_stall);
    check("stat_flush", stat_flush, m_flush);
`endif
  endtask

  // Memory returns the addressed words in the beat window of the outstanding request.
  task automatic apply(input logic rst, input logic rdy, input logic bsy, input logic rdr,
                       input logic [31:0] rpc);
    reset       = rst;
    insn_ready  = rdy;
    mem_busy    = bsy;
    redirect    = rdr;
    redirect_pc = rpc;
    if (m_last_beat >= 0 && cyc >= m_burst_start && cyc <= m_last_beat)
      mem_data_out = memword(m_burst_pc + 32'(4 * (cyc - m_burst_start)));
    else
      mem_data_out = $urandom;
    #1;
  endtask

  task automatic advance();
    compare_model();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle(input logic rst, input logic rdy, input logic bsy, input logic rdr,
                       input logic [31:0] rpc);
    apply(rst, rdy, bsy, rdr, rpc);
    advance();
  endtask

  initial begin
    vec_t tbl[11];
    // Cold start with decode always ready: reset cycle, then cycles c0..c9.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         START};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         START};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         START};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         START};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h11111111, 32'h80020000, START};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h22222222, 32'h80020004, START};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h33333333, 32'h80020008, START};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h44444444, 32'h8002000C, 32'h80020010};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         32'h80020010};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         32'h80020010};
    tbl[10] = '{1'b0, 1'b1, 1'b1, memword(32'h80020010), 32'h80020010, 32'h80020010};

    reset        = 1'b1;
    insn_ready   = 1'b0;
    mem_busy     = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    mem_data_out = '0;
    model_reset();
    @(posedge clock);
    #1;
    cyc = 0;

    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].rst, tbl[i].rdy, 1'b0, 1'b0, 32'h0);
      check($sformatf("tbl%0d_valid", i), 32'(insn_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl%0d_insn", i), insn, tbl[i].exp_insn);
        check($sformatf("tbl%0d_pc", i), insn_pc, tbl[i].exp_pc);
      end
      check($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].exp_addr);
      check($sformatf("tbl%0d_size", i), 32'(mem_acc_size), 32'h1);
      advance();
    end

    // Decode stalled: two bursts fill the FIFO, then nothing more is requested.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("fill_head_insn", insn, 32'h11111111);
    check("fill_head_pc", insn_pc, START);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill%0d_valid", i), 32'(insn_valid), 32'h1);
      check($sformatf("fill%0d_pc", i), insn_pc, START + 32'(4 * i));
      check($sformatf("fill%0d_insn", i), insn, memword(START + 32'(4 * i)));
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    end
    check("fill_drained", 32'(insn_valid), 32'h0);

    // Redirect during burst beat 1: two owed beats dropped, refetch at the aligned target.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h80020103);
    check("redir_flush", 32'(insn_valid), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_discard_addr", mem_addr, START);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_req_addr", mem_addr, 32'h80020100);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_not_yet", 32'(insn_valid), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_first_valid", 32'(insn_valid), 32'h1);
    check("redir_first_pc", insn_pc, 32'h80020100);
    check("redir_first_insn", insn, memword(32'h80020100));

    // Memory busy for 5 IDLE cycles: the request goes out the cycle busy falls.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (5) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("busy_no_data", 32'(insn_valid), 32'h0);
    check("busy_addr", mem_addr, START);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("busy_pre_valid", 32'(insn_valid), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("busy_valid", 32'(insn_valid), 32'h1);
    check("busy_pc", insn_pc, START);

    // Reset during WAIT abandons the burst and restarts at the start address.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("rstwait_valid", 32'(insn_valid), 32'h0);
    check("rstwait_addr", mem_addr, START);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("rstwait_refetch_valid", 32'(insn_valid), 32'h1);
    check("rstwait_refetch_pc", insn_pc, START);
    check("rstwait_refetch_insn", insn, 32'h11111111);

    // Fetch PC wraps past the top of the address space.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFFFFF2);
    check("wrap_req_addr", mem_addr, 32'hFFFFFFF0);
    repeat (6) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_next_addr", mem_addr, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFFFFC0 | ($urandom & 32'h3F);
      else                           rpc = START + ($urandom & 32'hFFF);
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
